// File: rtl/alu_seg_display.sv
// 7-segment display stage for the 8-bit ALU board. It captures the ALU snapshot and scans four
// common-anode digits across three pages: operands, result in hex and result in decimal.
module alu_seg_display #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       carry,
  input  logic       zero,
  input  logic       neg,
  input  logic       overflow,
  input  logic       btn_page,
  input  logic       sw_hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] page_led
);

  // state | meaning
  // P0    | operands A and B in hex
  // P1    | opcode, blank, result in hex
  // P2    | blank, result in decimal (hundreds, tens, units)
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    BLANK   = 5'd16;

  logic          btn_meta_q, btn_sync_q, hold_meta_q, hold_sync_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_state_q, db_state_d;
  logic          page_adv_q, page_adv_d;
  logic [1:0]    page_q, page_d;
  logic [7:0]    a_q, b_q, out_q;
  logic [2:0]    sel_q;
  logic [3:0]    flags_q;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [19:0]   bcd_w;
  logic [4:0]    code_w;
  logic          dp_w;

  function automatic logic [6:0] seg_of(input logic [4:0] c);
    case (c)
      5'd0:    seg_of = 7'h40;
      5'd1:    seg_of = 7'h79;
      5'd2:    seg_of = 7'h24;
      5'd3:    seg_of = 7'h30;
      5'd4:    seg_of = 7'h19;
      5'd5:    seg_of = 7'h12;
      5'd6:    seg_of = 7'h02;
      5'd7:    seg_of = 7'h78;
      5'd8:    seg_of = 7'h00;
      5'd9:    seg_of = 7'h10;
      5'd10:   seg_of = 7'h08;
      5'd11:   seg_of = 7'h03;
      5'd12:   seg_of = 7'h46;
      5'd13:   seg_of = 7'h21;
      5'd14:   seg_of = 7'h06;
      5'd15:   seg_of = 7'h0E;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      hold_meta_q <= 1'b0;
      hold_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_page;
      btn_sync_q  <= btn_meta_q;
      hold_meta_q <= sw_hold;
      hold_sync_q <= hold_meta_q;
    end
  end

  // Any cycle that agrees with the accepted level restarts the stability count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_state_d = db_state_q;
    page_adv_d = 1'b0;
    if (btn_sync_q == db_state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = '0;
      db_state_d = ~db_state_q;
      page_adv_d = ~db_state_q;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_comb begin
    page_d = page_q;
    if (page_adv_q) begin
      case (page_q)
        P0:      page_d = P1;
        P1:      page_d = P2;
        default: page_d = P0;
      endcase
    end else if (page_q != P0 && page_q != P1 && page_q != P2) begin
      page_d = P0;
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_cnt_q == RF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Shift-add-3: bcd_w[19:16] hundreds, [15:12] tens, [11:8] units once the loop finishes.
  always_comb begin
    bcd_w = {12'd0, out_q};
    for (int i = 0; i < 8; i++) begin
      if (bcd_w[11:8]  >= 4'd5) bcd_w[11:8]  = bcd_w[11:8]  + 4'd3;
      if (bcd_w[15:12] >= 4'd5) bcd_w[15:12] = bcd_w[15:12] + 4'd3;
      if (bcd_w[19:16] >= 4'd5) bcd_w[19:16] = bcd_w[19:16] + 4'd3;
      bcd_w = bcd_w << 1;
    end
  end

  always_comb begin
    code_w = BLANK;
    dp_w   = 1'b1;
    case (idx_q)
      2'd0: begin
        dp_w = ~flags_q[0];
        case (page_q)
          P1:      code_w = {1'b0, out_q[3:0]};
          P2:      code_w = {1'b0, bcd_w[11:8]};
          default: code_w = {1'b0, b_q[3:0]};
        endcase
      end
      2'd1: begin
        dp_w = ~flags_q[1];
        case (page_q)
          P1:      code_w = {1'b0, out_q[7:4]};
          P2:      code_w = {1'b0, bcd_w[15:12]};
          default: code_w = {1'b0, b_q[7:4]};
        endcase
      end
      2'd2: begin
        dp_w = ~flags_q[2];
        case (page_q)
          P1:      code_w = BLANK;
          P2:      code_w = {1'b0, bcd_w[19:16]};
          default: code_w = {1'b0, a_q[3:0]};
        endcase
      end
      default: begin
        dp_w = ~flags_q[3];
        case (page_q)
          P1:      code_w = {2'b00, sel_q};
          P2:      code_w = BLANK;
          default: code_w = {1'b0, a_q[7:4]};
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q   <= '0;
      db_state_q <= 1'b0;
      page_adv_q <= 1'b0;
      page_q     <= P0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      out_q      <= '0;
      flags_q    <= '0;
      ref_cnt_q  <= '0;
      idx_q      <= '0;
      an_q       <= 4'hF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_state_q <= db_state_d;
      page_adv_q <= page_adv_d;
      page_q     <= page_d;
      if (!hold_sync_q) begin
        a_q     <= alu_a;
        b_q     <= alu_b;
        sel_q   <= alu_sel;
        out_q   <= alu_out;
        flags_q <= {carry, zero, neg, overflow};
      end
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_q      <= ~(4'b0001 << idx_q);
      seg_q     <= seg_of(code_w);
      dp_q      <= dp_w;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign page_led = page_q;

endmodule

// File: tb/tb_alu_seg_display.sv
// Bench for alu_seg_display: directed vectors, expected digits queued by the stimulus and
// consumed by a monitor whenever the matching anode is active.
module tb_alu_seg_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_a = '0, alu_b = '0, alu_out = '0;
  logic [2:0] alu_sel = '0;
  logic       carry = 0, zero = 0, neg = 0, overflow = 0;
  logic       btn_page = 0, sw_hold = 0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] page_led;

  alu_seg_display #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .carry(carry), .zero(zero), .neg(neg), .overflow(overflow),
    .btn_page(btn_page), .sw_hold(sw_hold), .an(an), .seg(seg), .dp(dp), .page_led(page_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push4(input int tag, input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dps);
    exp_t e;
    e.tag = tag;
    e.an = 4'hE; e.seg = s0; e.dp = dps[0]; sb_q.push_back(e);
    e.an = 4'hD; e.seg = s1; e.dp = dps[1]; sb_q.push_back(e);
    e.an = 4'hB; e.seg = s2; e.dp = dps[2]; sb_q.push_back(e);
    e.an = 4'h7; e.seg = s3; e.dp = dps[3]; sb_q.push_back(e);
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_t%0d: got %0d pending expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic press();
    btn_page = 1'b1;
    tick(12);
    btn_page = 1'b0;
    tick(20);
  endtask

  // Monitor: pops the head entry when its anode is the one being driven.
  initial begin
    int stall;
    exp_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (rst_n && sb_q.size() > 0) begin
        if (an === sb_q[0].an) begin
          e = sb_q.pop_front();
          check($sformatf("seg_t%0d_an%0h", e.tag, e.an), 32'(seg), 32'(e.seg));
          check($sformatf("dp_t%0d_an%0h", e.tag, e.an), 32'(dp), 32'(e.dp));
          stall = 0;
        end else begin
          stall++;
          if (stall > 40) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout_t%0d: got an=%0h expected an=%0h", sb_q[0].tag, an, sb_q[0].an);
            void'(sb_q.pop_front());
            stall = 0;
          end
        end
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    tick(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_page", 32'(page_led), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'h40);

    // Operand page: A=3C, B=A5
    alu_a = 8'h3C;
    alu_b = 8'hA5;
    tick(6);
    push4(2, 7'h30, 7'h46, 7'h08, 7'h12, 4'b1111);
    drain(2);

    // Bounce must not advance the page
    repeat (3) begin
      btn_page = 1'b1;
      tick(5);
      btn_page = 1'b0;
      tick(5);
    end
    tick(10);
    check("bounce_page", 32'(page_led), 32'h0);
    press();
    check("press1_page", 32'(page_led), 32'h1);
    alu_sel = 3'd5;
    alu_out = 8'h9E;
    tick(6);
    push4(3, 7'h12, 7'h7F, 7'h10, 7'h06, 4'b1111);
    drain(3);
    press();
    check("press2_page", 32'(page_led), 32'h2);

    // Decimal page
    alu_out = 8'hFF;
    tick(6);
    push4(4, 7'h7F, 7'h24, 7'h12, 7'h12, 4'b1111);
    drain(4);
    alu_out = 8'h07;
    tick(6);
    push4(5, 7'h7F, 7'h40, 7'h40, 7'h78, 4'b1111);
    drain(5);

    // Hold freezes 0x11 (017) while input moves to 0x22 (034)
    alu_out = 8'h11;
    tick(6);
    push4(6, 7'h7F, 7'h40, 7'h79, 7'h78, 4'b1111);
    drain(6);
    sw_hold = 1'b1;
    tick(4);
    alu_out = 8'h22;
    tick(6);
    push4(7, 7'h7F, 7'h40, 7'h79, 7'h78, 4'b1111);
    drain(7);
    sw_hold = 1'b0;
    tick(7);
    push4(8, 7'h7F, 7'h40, 7'h30, 7'h19, 4'b1111);
    drain(8);
    press();
    check("press3_page", 32'(page_led), 32'h0);

    // Flags on decimal points: carry on digit3, overflow on digit0
    carry = 1'b1;
    overflow = 1'b1;
    tick(6);
    push4(9, 7'h30, 7'h46, 7'h08, 7'h12, 4'b0110);
    drain(9);
    zero = 1'b1;
    carry = 1'b0;
    tick(6);
    push4(10, 7'h30, 7'h46, 7'h08, 7'h12, 4'b1010);
    drain(10);

    // Asynchronous reset mid-scan
    press();
    check("press4_page", 32'(page_led), 32'h1);
    tick(2);
    rst_n = 1'b0;
    #2;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'h1);
    check("midrst_page", 32'(page_led), 32'h0);
    tick(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_an", 32'(an), 32'hE);
    check("rerst_seg", 32'(seg), 32'h40);
    check("rerst_dp", 32'(dp), 32'h1);
    tick(6);
    push4(11, 7'h30, 7'h46, 7'h08, 7'h12, 4'b1010);
    drain(11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
